// File: rtl/game_timer_bcd.sv
// N-digit BCD game timer: start/pause/resume, up or down count, expiry pulse and low-time warning.
// Optional feature: define TIMER_BONUS_EN to add the bonus input and saturating BCD time adder.
module game_timer_bcd #(
   parameter int                        CLK_FREQ   = 100_000_000,
   parameter int                        TICK_HZ    = 1,
   parameter int                        NUM_DIGITS = 2,
   parameter logic [4*NUM_DIGITS-1:0]   WARN_BCD   = 'h10,
   parameter logic [4*NUM_DIGITS-1:0]   BONUS_BCD  = 'h05
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   load_bcd,
   input  logic                      start,
   input  logic                      pause,
   input  logic                      mode_up,
`ifdef TIMER_BONUS_EN
   input  logic                      bonus,
`endif
   output logic [4*NUM_DIGITS-1:0]   digits,
   output logic                      running,
   output logic                      expired,
   output logic                      warn
);

   localparam int W     = 4 * NUM_DIGITS;
   localparam int DIV   = CLK_FREQ / TICK_HZ;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

   function automatic logic [W-1:0] all_nines();
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_DIGITS; i++) r[4*i +: 4] = 4'd9;
      return r;
   endfunction

   localparam logic [W-1:0] ALL9 = all_nines();

   function automatic logic bcd_legal(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

`ifdef TIMER_BONUS_EN
   // Ripple BCD add; a carry out of the top digit saturates to all-9s.
   function automatic logic [W-1:0] bcd_add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      logic [4:0]   s;
      logic         carry;
      r     = '0;
      carry = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, carry};
         if (s > 5'd9) begin
            s     = s - 5'd10;
            carry = 1'b1;
         end else begin
            carry = 1'b0;
         end
         r[4*i +: 4] = s[3:0];
      end
      if (carry) r = ALL9;
      return r;
   endfunction
`endif

   if (DIV < 2 || !bcd_legal(WARN_BCD) || !bcd_legal(BONUS_BCD)) begin : g_bad_param
      $error("game_timer_bcd: DIV must be >= 2 and WARN_BCD/BONUS_BCD must be legal BCD");
   end

   state_t             state_q, state_nxt;
   logic [W-1:0]       digits_q, count_nxt, count_step;
   logic [DIV_W-1:0]   div_q;
   logic               mode_q;
   logic               expired_q;
   logic               tick;
   logic               count_terminal;
   logic               start_terminal;
   logic               bonus_ok;

   // Count datapath: the value the digits take on this edge if nothing overrides it.
   always_comb begin
      tick       = (state_q == S_RUN) && !pause && (div_q == DIV_LAST);
      count_step = mode_q ? bcd_inc(digits_q) : bcd_dec(digits_q);
      bonus_ok   = 1'b0;
`ifdef TIMER_BONUS_EN
      bonus_ok   = bonus && !mode_q && ((state_q == S_RUN) || (state_q == S_PAUSED));
`endif
      count_nxt  = tick ? count_step : digits_q;
`ifdef TIMER_BONUS_EN
      if (bonus_ok) count_nxt = bcd_add_sat(count_nxt, BONUS_BCD);
`endif
      count_terminal = mode_q  ? (count_nxt == ALL9) : (count_nxt == '0);
      start_terminal = mode_up ? (digits_q == ALL9)  : (digits_q == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      if (load) begin
         state_nxt = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (start) state_nxt = start_terminal ? S_DONE : S_RUN;
            S_RUN:    if (pause) state_nxt = S_PAUSED;
                      else if (tick && count_terminal) state_nxt = S_DONE;
            S_PAUSED: if (start) state_nxt = S_RUN;
            default:  state_nxt = state_q;
         endcase
      end
   end

   // Divider, digits, latched mode and the expiry pulse register.
   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q  <= '0;
         div_q     <= '0;
         mode_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         expired_q <= (state_nxt == S_DONE) && (state_q != S_DONE);
         if (load) begin
            digits_q <= bcd_clamp(load_bcd);
            div_q    <= '0;
         end else begin
            digits_q <= count_nxt;
            case (state_q)
               S_IDLE: begin
                  div_q <= '0;
                  if (start) mode_q <= mode_up;
               end
               S_RUN: begin
                  // The cycle that takes a pause does not advance the fractional tick.
                  if (!pause) div_q <= tick ? '0 : div_q + 1'b1;
               end
               default: div_q <= div_q;
            endcase
         end
      end
   end

   always_comb begin
      digits  = digits_q;
      running = (state_q == S_RUN);
      expired = expired_q;
      warn    = ((state_q == S_RUN) || (state_q == S_PAUSED)) && !mode_q &&
                (digits_q != '0) && (digits_q <= WARN_BCD);
   end

endmodule
